wbuf_drain_sched: RTL and testbench

- Scheduler between the write buffer FIFO and the single DRAM-cache memory command port.
- Arbitrates between incoming read requests and draining buffered write entries.
- Policy: read priority, high/low watermark forced drain, starvation guard, opportunistic drain when idle.
- Tracks write-buffer occupancy internally from push/pop pulses.

---
 rtl/wbuf_drain_sched_if.sv | 26 ++
 rtl/wbuf_drain_sched.sv | 197 +++++++++++++++++++
 tb/tb_wbuf_drain_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbuf_drain_sched_if.sv
// Memory command channel between the write-buffer drain scheduler (master) and
// the DRAM-cache command port (slave).
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

interface wbuf_drain_sched_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = `AXI_DATA_WIDTH
);
    logic                  mem_valid_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ready_i;

    modport master (
        output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i
    );

    modport slave (
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i
    );
endinterface

// File: rtl/wbuf_drain_sched.sv
// Read-priority scheduler draining the write buffer onto the DRAM-cache command port,
// with watermark drain mode and a starvation guard. Optional perf counters: WBUF_SCHED_PERF_EN.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef FIFO_SIZE
`define FIFO_SIZE 16
`endif

module wbuf_drain_sched #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = `AXI_DATA_WIDTH,
    parameter int unsigned FIFO_SIZE    = `FIFO_SIZE,
    parameter int unsigned HI_WM        = FIFO_SIZE - 4,
    parameter int unsigned LO_WM        = 2,
    parameter int unsigned STARVE_LIMIT = 32,
    localparam int unsigned OCC_W       = $clog2(FIFO_SIZE + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wb_push_i,
    output logic                             wb_rden_o,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] wb_rdata_i,
    input  logic                             rd_valid_i,
    input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
    output logic                             rd_ready_o,
    wbuf_drain_sched_if.master               mem,
    output logic [OCC_W-1:0]                 occ_o,
    output logic                             drain_mode_o
`ifdef WBUF_SCHED_PERF_EN
    ,
    output logic [31:0]                      perf_wr_cnt_o,
    output logic [31:0]                      perf_rd_cnt_o,
    output logic [31:0]                      perf_drain_cyc_o
`endif
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_SIZE);
    localparam logic [OCC_W-1:0] OCC_HI   = OCC_W'(HI_WM);
    localparam logic [OCC_W-1:0] OCC_LO   = OCC_W'(LO_WM);
    localparam logic [SW-1:0]    STV_MAX  = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} state_e;

    state_e                  state_q, state_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic                    drain_q, drain_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic                    valid_q, valid_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    grant_wr, grant_rd;
    logic                    occ_nz;

    assign occ_nz = (occ_q != '0);

    // Grant strobes are decided in S_IDLE and reach the FIFO/requester in the same
    // cycle; this is what gives the 1-cycle read and 2-cycle write command latency.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (rst_n && state_q == S_IDLE) begin
            if (occ_nz && (drain_q || starve_q == STV_MAX)) begin
                grant_wr = 1'b1;
            end else if (rd_valid_i) begin
                grant_rd = 1'b1;
            end else if (occ_nz) begin
                grant_wr = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_wr) begin
                    state_d = S_FETCH;
                end else if (grant_rd) begin
                    addr_d  = rd_addr_i;
                    we_d    = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_FETCH: begin
                addr_d  = wb_rdata_i[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
                wdata_d = wb_rdata_i[DATA_WIDTH-1:0];
                we_d    = 1'b1;
                valid_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (valid_q && mem.mem_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        case ({wb_push_i, grant_wr})
            2'b10:   if (occ_q != OCC_FULL) occ_d = occ_q + OCC_W'(1);
            2'b01:   if (occ_nz) occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        drain_d = drain_q;
        if (occ_q >= OCC_HI) begin
            drain_d = 1'b1;
        end else if (occ_q <= OCC_LO) begin
            drain_d = 1'b0;
        end

        starve_d = starve_q;
        if (!occ_nz || grant_wr) begin
            starve_d = '0;
        end else if (grant_rd && starve_q != STV_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            occ_q    <= '0;
            drain_q  <= 1'b0;
            starve_q <= '0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            drain_q  <= drain_d;
            starve_q <= starve_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign wb_rden_o       = grant_wr;
    assign rd_ready_o      = grant_rd;
    assign mem.mem_valid_o = valid_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign occ_o           = occ_q;
    assign drain_mode_o    = drain_q;

`ifdef WBUF_SCHED_PERF_EN
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_dc_q, perf_dc_d;
    logic        hs;

    assign hs = valid_q && mem.mem_ready_i;

    always_comb begin
        perf_wr_d = perf_wr_q;
        perf_rd_d = perf_rd_q;
        perf_dc_d = perf_dc_q;
        if (hs && we_q)  perf_wr_d = perf_wr_q + 32'd1;
        if (hs && !we_q) perf_rd_d = perf_rd_q + 32'd1;
        if (drain_q)     perf_dc_d = perf_dc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_wr_q <= '0;
            perf_rd_q <= '0;
            perf_dc_q <= '0;
        end else begin
            perf_wr_q <= perf_wr_d;
            perf_rd_q <= perf_rd_d;
            perf_dc_q <= perf_dc_d;
        end
    end

    assign perf_wr_cnt_o    = perf_wr_q;
    assign perf_rd_cnt_o    = perf_rd_q;
    assign perf_drain_cyc_o = perf_dc_q;
`endif

endmodule

// File: tb/tb_wbuf_drain_sched.sv
// Directed bench for wbuf_drain_sched: reset, read/write latency, FIFO-order drain,
// stall stability, same-cycle push/pop, starvation guard and watermark drain mode.
module tb_wbuf_drain_sched;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned FS = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wb_push_i;
    logic               wb_rden_o;
    logic [AW+DW-1:0]   wb_rdata_i;
    logic               rd_valid_i;
    logic [AW-1:0]      rd_addr_i;
    logic               rd_ready_o;
    logic [4:0]         occ_o;
    logic               drain_mode_o;
`ifdef WBUF_SCHED_PERF_EN
    logic [31:0]        perf_wr_cnt_o, perf_rd_cnt_o, perf_drain_cyc_o;
`endif

    wbuf_drain_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    wbuf_drain_sched #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FIFO_SIZE   (FS),
        .HI_WM       (12),
        .LO_WM       (2),
        .STARVE_LIMIT(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_push_i   (wb_push_i),
        .wb_rden_o   (wb_rden_o),
        .wb_rdata_i  (wb_rdata_i),
        .rd_valid_i  (rd_valid_i),
        .rd_addr_i   (rd_addr_i),
        .rd_ready_o  (rd_ready_o),
        .mem         (mem_if),
        .occ_o       (occ_o),
        .drain_mode_o(drain_mode_o)
`ifdef WBUF_SCHED_PERF_EN
        ,
        .perf_wr_cnt_o   (perf_wr_cnt_o),
        .perf_rd_cnt_o   (perf_rd_cnt_o),
        .perf_drain_cyc_o(perf_drain_cyc_o)
`endif
    );

    always #5 clk = ~clk;

    // Write-buffer FIFO stand-in: pop data appears the cycle after wb_rden_o.
    logic [AW+DW-1:0] fifo_q[$];
    logic [AW+DW-1:0] push_data;
    always @(posedge clk) begin
        if (!rst_n) begin
            fifo_q.delete();
            wb_rdata_i <= '0;
        end else begin
            if (wb_push_i) fifo_q.push_back(push_data);
            if (wb_rden_o && fifo_q.size() > 0) wb_rdata_i <= fifo_q.pop_front();
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] ent_addr(input int i);
        return 32'hA000_0000 + 32'(i) * 32'd16;
    endfunction

    function automatic logic [31:0] ent_data(input int i);
        return 32'h5A5A_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic adv();
        nxt();
        smp();
    endtask

    task automatic wait_sig(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if ((which == 0 && wb_rden_o) || (which == 1 && mem_if.mem_valid_o) ||
                (which == 2 && rd_ready_o) || (which == 3 && drain_mode_o) ||
                (which == 4 && !drain_mode_o) || (which == 5 && occ_o == 5'd0)) begin
                ok = 1'b1;
                break;
            end
            adv();
        end
    endtask

    // From a wb_rden_o cycle: FETCH, then the write command must present the entry.
    task automatic chk_write(input string tag, input int idx);
        adv();
        adv();
        chk({tag, "_valid"}, mem_if.mem_valid_o, 1);
        chk({tag, "_we"},    mem_if.mem_we_o, 1);
        chk({tag, "_addr"},  mem_if.mem_addr_o, ent_addr(idx));
        chk({tag, "_data"},  mem_if.mem_wdata_o, ent_data(idx));
        adv();
    endtask

    initial begin
        bit ok;
        int cnt, rd_cnt, wr_cnt;

        // ---- reset with requests held active ----
        rst_n = 1'b0;
        wb_push_i = 1'b1;
        push_data = {ent_addr(99), ent_data(99)};
        rd_valid_i = 1'b1;
        rd_addr_i = 32'h100;
        mem_if.mem_ready_i = 1'b1;
        nxt();
        nxt();
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rst_rd_ready", rd_ready_o, 0);
            chk("rst_rden", wb_rden_o, 0);
            chk("rst_valid", mem_if.mem_valid_o, 0);
            chk("rst_we", mem_if.mem_we_o, 0);
            chk("rst_addr", mem_if.mem_addr_o, 0);
            chk("rst_wdata", mem_if.mem_wdata_o, 0);
            chk("rst_occ", occ_o, 0);
            chk("rst_drain", drain_mode_o, 0);
            nxt();
        end

        // ---- single read right after reset release ----
        rst_n = 1'b1;
        wb_push_i = 1'b0;
        smp();
        chk("rd_ready_T", rd_ready_o, 1);
        chk("rd_valid_T", mem_if.mem_valid_o, 0);
        nxt();
        rd_valid_i = 1'b0;
        smp();
        chk("rd_valid_T1", mem_if.mem_valid_o, 1);
        chk("rd_we_T1", mem_if.mem_we_o, 0);
        chk("rd_addr_T1", mem_if.mem_addr_o, 32'h100);
        chk("rd_ready_T1", rd_ready_o, 0);
        adv();
        chk("rd_valid_T2", mem_if.mem_valid_o, 0);

        // ---- 3 pushes behind a stalled read, then drain in FIFO order ----
        nxt();
        rd_valid_i = 1'b1;
        rd_addr_i = 32'h200;
        mem_if.mem_ready_i = 1'b0;
        smp();
        chk("a_rd_ready", rd_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            nxt();
            rd_valid_i = 1'b0;
            wb_push_i = 1'b1;
            push_data = {ent_addr(i), ent_data(i)};
            smp();
        end
        nxt();
        wb_push_i = 1'b0;
        smp();
        chk("a_occ3", occ_o, 3);
        chk("a_hold_addr", mem_if.mem_addr_o, 32'h200);
        chk("a_hold_valid", mem_if.mem_valid_o, 1);
        chk("a_no_rden", wb_rden_o, 0);
        nxt();
        mem_if.mem_ready_i = 1'b1;
        smp();
        adv();
        chk("a_rd_done", mem_if.mem_valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            wait_sig(0, 10, ok);
            chk("a_rden_seen", ok, 1);
            chk("a_occ_step", occ_o, 3 - i);
            chk_write("a_wr", i);
        end
        chk("a_occ0", occ_o, 0);
        chk("a_rden_empty", wb_rden_o, 0);

        // ---- occ=4 same-cycle push/pop, then a write stalled 5 cycles ----
        nxt();
        rd_valid_i = 1'b1;
        rd_addr_i = 32'h300;
        mem_if.mem_ready_i = 1'b0;
        smp();
        chk("b_rd_ready", rd_ready_o, 1);
        for (int i = 3; i < 7; i++) begin
            nxt();
            rd_valid_i = 1'b0;
            wb_push_i = 1'b1;
            push_data = {ent_addr(i), ent_data(i)};
            smp();
        end
        nxt();
        wb_push_i = 1'b0;
        mem_if.mem_ready_i = 1'b1;
        smp();
        chk("b_occ4", occ_o, 4);
        nxt();
        wb_push_i = 1'b1;
        push_data = {ent_addr(7), ent_data(7)};
        smp();
        chk("b_pp_rden", wb_rden_o, 1);
        chk("b_pp_occ_before", occ_o, 4);
        nxt();
        wb_push_i = 1'b0;
        mem_if.mem_ready_i = 1'b0;
        rd_valid_i = 1'b1;
        rd_addr_i = 32'h400;
        smp();
        chk("b_pp_occ_after", occ_o, 4);
        chk("b_fetch_no_rd", rd_ready_o, 0);
        for (int k = 0; k < 5; k++) begin
            adv();
            chk("b_stall_valid", mem_if.mem_valid_o, 1);
            chk("b_stall_we", mem_if.mem_we_o, 1);
            chk("b_stall_addr", mem_if.mem_addr_o, ent_addr(3));
            chk("b_stall_data", mem_if.mem_wdata_o, ent_data(3));
            chk("b_stall_rd_ready", rd_ready_o, 0);
            chk("b_stall_rden", wb_rden_o, 0);
        end
        nxt();
        mem_if.mem_ready_i = 1'b1;
        smp();
        chk("b_hs_valid", mem_if.mem_valid_o, 1);
        adv();
        chk("b_after_valid", mem_if.mem_valid_o, 0);
        chk("b_after_rd_ready", rd_ready_o, 1);
        chk("b_after_rden", wb_rden_o, 0);
        nxt();
        rd_valid_i = 1'b0;
        smp();
        chk("b_rd_addr", mem_if.mem_addr_o, 32'h400);
        chk("b_rd_we", mem_if.mem_we_o, 0);
        adv();
        for (int i = 4; i < 8; i++) begin
            wait_sig(0, 10, ok);
            chk("b_rden_seen", ok, 1);
            chk("b_occ_step", occ_o, 8 - i);
            chk_write("b_wr", i);
        end
        chk("b_occ0", occ_o, 0);

        // ---- starvation guard: one entry vs continuous reads ----
        nxt();
        wb_push_i = 1'b1;
        push_data = {ent_addr(8), ent_data(8)};
        smp();
        chk("c_no_rden_occ0", wb_rden_o, 0);
        nxt();
        wb_push_i = 1'b0;
        rd_valid_i = 1'b1;
        rd_addr_i = 32'h500;
        smp();
        chk("c_occ1", occ_o, 1);
        chk("c_first_rd", rd_ready_o, 1);
        cnt = 0;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (wb_rden_o) begin
                ok = 1'b1;
                break;
            end
            if (rd_ready_o) cnt++;
            adv();
        end
        chk("c_forced_write_seen", ok, 1);
        chk("c_read_grants", cnt, 32);
        chk_write("c_wr", 8);
        chk("c_rd_resume", rd_ready_o, 1);
        chk("c_occ0", occ_o, 0);
        nxt();
        rd_valid_i = 1'b0;
        smp();
        chk("c_rd_addr", mem_if.mem_addr_o, 32'h500);
        adv();

        // ---- watermark drain: 12 pushes under continuous reads ----
        for (int i = 0; i < 12; i++) begin
            nxt();
            wb_push_i = 1'b1;
            push_data = {ent_addr(10 + i), ent_data(10 + i)};
            rd_valid_i = 1'b1;
            rd_addr_i = 32'h600;
            smp();
        end
        nxt();
        wb_push_i = 1'b0;
        smp();
        wait_sig(3, 20, ok);
        chk("d_drain_rise", ok, 1);
        chk("d_occ_at_rise", occ_o, 12);
        rd_cnt = 0;
        wr_cnt = 0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (!drain_mode_o) begin
                ok = 1'b1;
                break;
            end
            if (rd_ready_o) rd_cnt++;
            if (wb_rden_o) wr_cnt++;
            adv();
        end
        chk("d_drain_fall", ok, 1);
        chk("d_reads_in_drain", rd_cnt, 0);
        chk("d_writes_in_drain", wr_cnt, 10);
        chk("d_occ_at_fall", occ_o, 2);
        wait_sig(2, 10, ok);
        chk("d_rd_resume", ok, 1);
        chk("d_rd_resume_occ", occ_o, 2);
        nxt();
        rd_valid_i = 1'b0;
        smp();
        wait_sig(5, 40, ok);
        chk("d_final_empty", ok, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
